// File: rtl/bus_pkg.sv
// Shared types and default sizing for the system-bus arbiter and its master ports.
package bus_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    TURN    = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_TIMEOUT     = 64;
endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the master ports and the bus arbiter.
interface bus_arbiter_if import bus_pkg::*; #(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS
) ();
  localparam int OW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant;
  logic [OW-1:0]          owner;
  logic                   bus_busy;
  logic                   timeout_evt;

  modport master (output req, input grant, input owner, input bus_busy, input timeout_evt);
  modport slave  (input req, output grant, output owner, output bus_busy, output timeout_evt);
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after i_ptr, wrapping.
module rr_pick #(
  parameter int NUM_MASTERS = 2,
  localparam int OW = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [OW-1:0]          i_ptr,
  output logic [OW-1:0]          o_sel,
  output logic                   o_any
);
  int w_idx;

  // Scan from the farthest offset down so the nearest hit overwrites last.
  always_comb begin
    o_sel = '0;
    o_any = |i_req;
    w_idx = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % NUM_MASTERS;
      if (i_req[w_idx]) o_sel = OW'(w_idx);
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system-bus arbiter with one-cycle turnaround and hold timeout.
module bus_arbiter import bus_pkg::*; #(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rstn,
  bus_arbiter_if.slave  bus
);
  localparam int OW    = $clog2(NUM_MASTERS);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] SAT      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LIM = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : CNT_W'(0);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_GRANTED = GRANTED;
  localparam logic [1:0] S_TURN    = TURN;

  logic [1:0]             r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [OW-1:0]          r_owner;
  logic                   r_busy;
  logic                   r_tevt;
  logic [OW-1:0]          r_ptr;
  logic [CNT_W-1:0]       r_hold;

  logic [OW-1:0] w_sel;
  logic          w_any;
  logic          w_own_req;
  logic          w_others;
  logic          w_to_hit;
  logic [OW-1:0] w_next_ptr;

  rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_sel (w_sel),
    .o_any (w_any)
  );

  // r_grant is one-hot on the owner while GRANTED, so it doubles as the owner mask.
  assign w_own_req  = |(bus.req & r_grant);
  assign w_others   = |(bus.req & ~r_grant);
  assign w_to_hit   = (TIMEOUT != 0) && (r_hold >= HOLD_LIM);
  assign w_next_ptr = (r_owner == OW'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_busy  <= 1'b0;
      r_tevt  <= 1'b0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_tevt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= NUM_MASTERS'(1) << w_sel;
            r_owner <= w_sel;
            r_busy  <= 1'b1;
            r_hold  <= '0;
            r_state <= S_GRANTED;
          end
        end
        S_GRANTED: begin
          if (r_hold != SAT) r_hold <= r_hold + 1'b1;
          if (!w_own_req || (w_to_hit && w_others)) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
            r_tevt  <= w_own_req;
            r_state <= S_TURN;
          end
        end
        S_TURN:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.owner       = r_owner;
  assign bus.bus_busy    = r_busy;
  assign bus.timeout_evt = r_tevt;

  a_onehot:  assert property (@(posedge clk) disable iff (!rstn) $onehot0(r_grant));
  a_busy:    assert property (@(posedge clk) disable iff (!rstn) r_busy == |r_grant);
  a_owner:   assert property (@(posedge clk) disable iff (!rstn) r_busy |-> r_grant[r_owner]);
  a_tevt:    assert property (@(posedge clk) disable iff (!rstn) !(r_tevt && r_busy));
endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed scoreboard bench for bus_arbiter against a cycle-level reference model.
module tb_bus_arbiter;
  localparam int NM = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_MASTERS(NM)) bif ();
  bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT(TO)) dut (.clk(clk), .rstn(rstn), .bus(bif));

  typedef struct {
    logic [NM-1:0] grant;
    int            owner;
    logic          busy;
    logic          tevt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // reference model: who owns the bus, for how long, and whether a gap is pending
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_gap   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_ptr = 0; m_gap = 0;
  endtask

  task automatic release_bus(input bit tevt, inout exp_t e);
    m_ptr   = (m_owner + 1) % NM;
    m_owner = -1;
    m_gap   = 2;
    e.tevt  = tevt;
  endtask

  task automatic step(input logic [NM-1:0] r);
    exp_t e;
    logic [NM-1:0] others;
    e.tevt = 1'b0;
    if (m_owner >= 0) begin
      m_held++;
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) release_bus(1'b0, e);
      else if (TO != 0 && m_held >= TO && others != '0) release_bus(1'b1, e);
    end else if (m_gap > 0) begin
      m_gap--;
    end
    // the second gap cycle is the arbitration cycle itself
    if (m_owner < 0 && m_gap == 1) m_gap = 0;
    else if (m_owner < 0 && m_gap == 0 && !e.tevt && r != '0 && !(m_held < 0)) begin
      if (!(e.tevt) && q.size() >= 0) begin
        for (int k = 0; k < NM; k++) begin
          if (r[(m_ptr + k) % NM]) begin
            m_owner = (m_ptr + k) % NM;
            m_held  = 0;
            break;
          end
        end
      end
    end
    e.grant = '0;
    if (m_owner >= 0) e.grant[m_owner] = 1'b1;
    e.busy  = (m_owner >= 0);
    e.owner = m_owner;
    q.push_back(e);
  endtask

  logic [NM-1:0] want;

  task automatic cyc(input logic [NM-1:0] r, input logic rst_val);
    @(negedge clk);
    rstn = rst_val;
    bif.req = r;
    if (rstn) step(r);
    else model_reset();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        q.delete();
        chk("rst_grant", int'(bif.grant), 0);
        chk("rst_busy", int'(bif.bus_busy), 0);
        chk("rst_tevt", int'(bif.timeout_evt), 0);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        chk("grant", int'(bif.grant), int'(e.grant));
        chk("busy", int'(bif.bus_busy), int'(e.busy));
        chk("tevt", int'(bif.timeout_evt), int'(e.tevt));
        if (e.busy) chk("owner", int'(bif.owner), e.owner);
      end
    end
  end

  initial begin
    logic comp;
    bif.req = '1;
    rstn = 1'b0;
    for (int i = 0; i < 20; i++) cyc('1, 1'b0);
    for (int i = 0; i < 4; i++) cyc('1, 1'b1);
    for (int i = 0; i < 4; i++) cyc('0, 1'b1);

    // single master
    for (int i = 0; i < 10; i++) cyc(3'b010, 1'b1);
    for (int i = 0; i < 4; i++) cyc('0, 1'b1);

    // contention: owner drops req for one cycle after holding a while
    for (int i = 0; i < 60; i++) begin
      logic [NM-1:0] r;
      r = '1;
      if (m_owner >= 0 && m_held == 5) r[m_owner] = 1'b0;
      cyc(r, 1'b1);
    end
    for (int i = 0; i < 4; i++) cyc('0, 1'b1);

    // timeout: master1 joins at master0's third grant cycle
    comp = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_owner == 0 && m_held == 2) comp = 1'b1;
      cyc(comp ? 3'b011 : 3'b001, 1'b1);
    end
    for (int i = 0; i < 4; i++) cyc('0, 1'b1);

    // no competitor: hold indefinitely, then revoke as soon as someone arrives
    for (int i = 0; i < 200; i++) cyc(3'b001, 1'b1);
    for (int i = 0; i < 20; i++) cyc(3'b011, 1'b1);
    for (int i = 0; i < 4; i++) cyc('0, 1'b1);

    // random traffic; requesters hold until granted, owners drop at random
    want = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NM; i++) begin
        if (!want[i] && ($urandom % 5) == 0) want[i] = 1'b1;
        else if (want[i] && m_owner == i && ($urandom % 6) == 0) want[i] = 1'b0;
      end
      cyc(want, 1'b1);
    end
    for (int i = 0; i < 4; i++) cyc('0, 1'b1);

    // async reset mid-grant; rr_ptr must go back to 0
    for (int i = 0; i < 4; i++) cyc(3'b010, 1'b1);
    for (int i = 0; i < 3; i++) cyc('0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(3'b010, 1'b1);
    @(negedge clk);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("async_grant", int'(bif.grant), 0);
    chk("async_busy", int'(bif.bus_busy), 0);
    for (int i = 0; i < 3; i++) cyc(3'b110, 1'b0);
    for (int i = 0; i < 8; i++) cyc(3'b110, 1'b1);
    for (int i = 0; i < 4; i++) cyc('0, 1'b1);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares the serial system bus between NUM_MASTERS master ports.
- Each master port raises a request before starting a transaction and keeps it high until its transaction completes (ack/slave_valid handshake done).
- The arbiter issues one-hot grants, inserts a one-cycle turnaround between owners, and forcibly revokes ownership after a hold timeout if other masters are waiting.
- Its outputs also drive the bus mux select for the shared wr_bus/mode lines.

Parameters:
- NUM_MASTERS, 2, number of requesting master ports (2..8).
- TIMEOUT, 64, maximum grant hold in cycles while another request is pending; 0 disables timeout.
- CNT_W, $clog2(TIMEOUT+1), hold-counter width (derived, not overridden).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- req  input  NUM_MASTERS  per-master bus request, level-held for the whole transaction.
- grant  output  NUM_MASTERS  one-hot (or zero) bus grant.
- owner  output  $clog2(NUM_MASTERS)  index of the current owner; valid when bus_busy=1.
- bus_busy  output  1  high while any grant is asserted.
- timeout_evt  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (rstn=0, async): state=IDLE, grant=0, owner=0, bus_busy=0, timeout_evt=0, rr_ptr=0, hold_cnt=0. Deassertion is honoured on the next rising edge.
- Registered outputs only; no combinational path from req to grant.
- IDLE:
  - If any req bit is set, pick the first set bit scanning from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_MASTERS-1, 0, ...).
  - Next cycle: grant[sel]=1, owner=sel, bus_busy=1, hold_cnt=0, state=GRANTED.
  - Request-to-grant latency is exactly 1 cycle from IDLE.
- GRANTED:
  - hold_cnt increments each cycle and saturates at TIMEOUT.
  - If req[owner]=0: grant=0, bus_busy=0, rr_ptr=(owner+1) mod NUM_MASTERS, state=TURN.
  - Else if TIMEOUT!=0, hold_cnt==TIMEOUT-1, and any other req bit is set: grant=0, bus_busy=0, timeout_evt=1 for one cycle, rr_ptr=(owner+1) mod NUM_MASTERS, state=TURN.
  - If no other master is waiting, the owner holds the bus indefinitely and the counter stays saturated. If a competitor then arrives with the counter saturated, revoke on the next cycle.
- TURN: exactly one cycle with all grants low, then go to IDLE. Arbitration happens in IDLE, so the minimum gap between two owners is 2 idle cycles: TURN plus the IDLE evaluation cycle.
- A revoked master still holding req re-enters arbitration normally. It has lowest priority because rr_ptr has advanced past it.
- req changes on non-owner bits during GRANTED have no effect on grant.
- A req pulse that rises and falls while in TURN is not seen. Requesters must hold req until granted.
- Invariants, checked by assertion:
  - grant is zero or one-hot.
  - bus_busy == |grant.
  - grant[owner]==1 whenever bus_busy.
  - timeout_evt never high while bus_busy=1.
- Owner index arithmetic is modulo NUM_MASTERS; for non-power-of-2 counts, rr_ptr wraps from NUM_MASTERS-1 to 0.

Decomposition:
- Shared package bus_pkg:
  - arb_state_t enum {IDLE, GRANTED, TURN}.
  - Default NUM_MASTERS and TIMEOUT constants used by the top-level bus and master_port instances.
- One natural sub-module: rr_pick, a combinational round-robin priority selector taking req and rr_ptr and returning sel index plus an any_req flag. The arbiter FSM and hold counter stay in bus_arbiter.

Test Plan:
- Reset: hold rstn=0 with req=2'b11 for 20 ps-cycles -> grant=0, bus_busy=0, timeout_evt=0 throughout. After release, grant=2'b01 exactly one cycle after the first clock edge in IDLE.
- Single master: req=2'b10 for 10 cycles, then 0 -> grant=2'b10, owner=1 from cycle 1 through cycle 10. grant=0 in the cycle after req drops; state returns to IDLE after TURN.
- Contention fairness: req=2'b11 held, each master drops req for one cycle after 5 cycles granted -> grants alternate 01,10,01,10 with exactly 2 grant-free cycles between owners.
- Timeout with TIMEOUT=8: master0 holds req; master1 requests at grant cycle 3 -> grant revoked after master0 has held 8 cycles, timeout_evt pulses once, master1 is granted 2 cycles later.
- No competitor: master0 holds req for 200 cycles with TIMEOUT=8 -> never revoked, timeout_evt stays 0. Master1 requests at cycle 200 -> revoke on the next cycle.
- Async reset mid-grant: rstn falls between edges while grant=2'b10 -> grant=0 and bus_busy=0 immediately (before the next edge), rr_ptr=0.
